// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU.
// Runs one single-word load or store on a request/acknowledge data-memory bus.
// It returns load data for writeback and pulses done, or done+error, to the control FSM.
// Only word alignment is enforced. Misaligned requests never reach the bus.
// Optional feature: define LSU_TIMEOUT_EN to abort a request that waits TIMEOUT_CYCLES
// cycles without mem_ack. The default build waits for mem_ack indefinitely.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic aligned;
  logic launch;
  logic load_hit;
  logic tmo_hit;

  assign aligned  = (address[1:0] == 2'b00);
  // A new access is accepted only from IDLE; start while busy is dropped.
  assign launch   = (state == S_IDLE) && start && aligned;
  // mem_we holds the latched is_store for the whole transaction.
  assign load_hit = (state == S_REQ) && mem_ack && !mem_we;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The count reaches TIMEOUT_CYCLES on the edge that ends the last allowed REQ cycle.
  // An ack seen on that same edge still wins, because REQ checks mem_ack first.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter: held at zero outside REQ, counts REQ cycles without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != S_REQ) begin
      tmo_cnt <= '0;
    end else if (!mem_ack) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = aligned ? S_REQ : S_FAULT;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs.
  // The bus and busy follow the state being entered, so mem_req rises on the accepting edge.
  // done and error follow the state being left, so a DONE or FAULT cycle produces a
  // one-cycle pulse on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      busy    <= (state_nxt != S_IDLE);
      mem_req <= (state_nxt == S_REQ);
      done    <= (state == S_DONE) || (state == S_FAULT);
      error   <= (state == S_FAULT);
      if (launch) begin
        mem_we    <= is_store;
        mem_addr  <= address;
        mem_wdata <= store_data;
      end
      if (load_hit) begin
        load_data <= mem_rdata;
      end
    end
  end

endmodule
